instr_sequencer: RTL and testbench

// Instruction source feeding the Processador instr port and consuming its result/flags.

---
 rtl/instr_sequencer.sv | 138 +++++++++++++
 tb/tb_instr_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Program sequencer: fetches words from a small RAM, runs JMP/JZ/JC/HALT
// itself and hands every other word to the core, then latches its result.
module instr_sequencer #(
  parameter int ADDR_W  = 4,
  parameter int RES_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [7:0]        prog_data,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        result,
  input  logic              zero_flag,
  input  logic              carry_flag,
  input  logic              overflow_flag,
  output logic [7:0]        instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [7:0]        last_result,
  output logic              last_z,
  output logic              last_c,
  output logic              last_v,
  output logic              busy,
  output logic              done
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CW    = (RES_LAT > 1) ? $clog2(RES_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t            state, state_n;
  logic [7:0]        ram [DEPTH];
  logic [7:0]        ir;
  logic [CW-1:0]     cnt, cnt_n;
  logic [ADDR_W-1:0] pc_n, pc_inc, tgt;
  logic              cap;
  logic              quiet;

  assign pc_inc = pc + ADDR_W'(1);
  assign tgt    = ir[ADDR_W-1:0];
  assign quiet  = (state == S_IDLE) || (state == S_DONE);

  always_comb begin
    state_n = state;
    pc_n    = pc;
    cnt_n   = cnt;
    cap     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          pc_n    = '0;
          state_n = S_FETCH;
        end
      end
      S_FETCH: state_n = S_DECODE;
      S_DECODE: begin
        state_n = S_FETCH;
        unique case (1'b1)
          (ir == 8'hF0):     state_n = S_DONE;
          (ir[7:4] == 4'hD): pc_n = tgt;
          (ir[7:4] == 4'hE): pc_n = last_z ? tgt : pc_inc;
          (ir[7:4] == 4'hC): pc_n = last_c ? tgt : pc_inc;
          default:           state_n = S_ISSUE;
        endcase
      end
      S_ISSUE: begin
        cnt_n   = CW'(RES_LAT - 1);
        state_n = S_WAIT;
      end
      S_WAIT: begin
        if (cnt == '0) begin
          cap     = 1'b1;
          pc_n    = pc_inc;
          state_n = S_FETCH;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      S_DONE: begin
        if (start) begin
          pc_n    = '0;
          state_n = S_FETCH;
        end
      end
      default: state_n = S_IDLE;
    endcase
    // abort leaves pc where it was and drops any pending capture
    if (abort) begin
      state_n = S_IDLE;
      pc_n    = pc;
      cap     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      pc          <= '0;
      ir          <= '0;
      cnt         <= '0;
      last_result <= '0;
      last_z      <= 1'b0;
      last_c      <= 1'b0;
      last_v      <= 1'b0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      cnt   <= cnt_n;
      if (state == S_FETCH) ir <= ram[pc];
      if (cap) begin
        last_result <= result;
        last_z      <= zero_flag;
        last_c      <= carry_flag;
        last_v      <= overflow_flag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (prog_we && quiet) ram[prog_addr] <= prog_data;
  end

  assign instr_valid = (state == S_ISSUE);
  assign instr       = instr_valid ? ir : 8'h00;
  assign busy        = !quiet;
  assign done        = (state == S_DONE);

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: program interpreter model feeds an issue
// scoreboard; a core stand-in answers each issued word from a table.
module tb_instr_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       prog_we = 1'b0;
  logic [3:0] prog_addr = '0;
  logic [7:0] prog_data = '0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] result = '0;
  logic       zero_flag = 1'b0;
  logic       carry_flag = 1'b0;
  logic       overflow_flag = 1'b0;
  logic [7:0] instr;
  logic       instr_valid;
  logic [3:0] pc;
  logic [7:0] last_result;
  logic       last_z, last_c, last_v;
  logic       busy, done;

  instr_sequencer #(.ADDR_W(4), .RES_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .start(start), .abort(abort),
    .result(result), .zero_flag(zero_flag),
    .carry_flag(carry_flag), .overflow_flag(overflow_flag),
    .instr(instr), .instr_valid(instr_valid), .pc(pc),
    .last_result(last_result), .last_z(last_z), .last_c(last_c),
    .last_v(last_v), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // core stand-in tables
  logic [7:0] core_r [256];
  logic       core_c [256];
  logic       core_v [256];

  // model state
  logic [7:0] img [16];
  logic [7:0] ld  [16];
  logic [7:0] exp_q [$];
  logic [7:0] m_r, e_r;
  logic       m_z, m_c, m_v, e_z, e_c, e_v;
  int         e_pc, e_cyc;
  bit         sb_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (instr_valid) begin
      result        = core_r[instr];
      zero_flag     = (core_r[instr] == 8'h00);
      carry_flag    = core_c[instr];
      overflow_flag = core_v[instr];
    end
  end

  always @(negedge clk) begin
    if (!rst && !instr_valid) chk("nop_when_idle", instr, 8'h00);
    if (sb_en && instr_valid) begin
      if (exp_q.size() == 0) begin
        chk("issue_unexpected", {24'd0, instr}, 32'hFFFF_FFFF);
      end else begin
        chk("issue_instr", instr, exp_q.pop_front());
      end
    end
  end

  // Interpret img from pc=0 starting with the committed flags m_*.
  task automatic model_run(output bit ok);
    int p = 0;
    int cyc = 0;
    logic [7:0] w;
    logic [7:0] r = m_r;
    logic z = m_z, c = m_c, v = m_v;
    ok = 1'b0;
    exp_q.delete();
    for (int s = 0; s < 64; s++) begin
      w = img[p];
      cyc += 2;
      if (w == 8'hF0) begin
        ok = 1'b1;
        break;
      end
      case (w[7:4])
        4'hD: p = int'(w[3:0]);
        4'hE: p = z ? int'(w[3:0]) : (p + 1) % 16;
        4'hC: p = c ? int'(w[3:0]) : (p + 1) % 16;
        default: begin
          exp_q.push_back(w);
          cyc += 2;
          r = core_r[w];
          z = (r == 8'h00);
          c = core_c[w];
          v = core_v[w];
          p = (p + 1) % 16;
        end
      endcase
    end
    e_pc = p; e_cyc = cyc;
    e_r = r; e_z = z; e_c = c; e_v = v;
    if (!ok) exp_q.delete();
  endtask

  task automatic load_prog();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      prog_we = 1'b1;
      prog_addr = 4'(i);
      prog_data = ld[i];
    end
    @(negedge clk);
    prog_we = 1'b0;
    for (int i = 0; i < 16; i++) img[i] = ld[i];
  endtask

  // Start a run (optionally writing in the start cycle) and check it at done.
  task automatic run_prog(input string nm, input bit wr, input logic [3:0] wa,
                          input logic [7:0] wd, input int inj, output int cyc);
    bit ok;
    if (wr) img[wa] = wd;
    model_run(ok);
    if (!ok) chk({nm, "_model_halts"}, 0, 1);
    sb_en = 1'b1;
    @(negedge clk);
    start = 1'b1;
    prog_we = wr;
    prog_addr = wa;
    prog_data = wd;
    @(posedge clk);
    cyc = 0;
    while (1) begin
      @(negedge clk);
      start = 1'b0;
      prog_we = 1'b0;
      if (cyc == inj) begin
        prog_we = 1'b1;
        prog_addr = 4'd2;
        prog_data = 8'hAA;
        start = 1'b1;
      end
      if (done) break;
      if (cyc > 2000) break;
      @(posedge clk);
      cyc++;
    end
    start = 1'b0;
    prog_we = 1'b0;
    chk({nm, "_done"}, done, 1'b1);
    chk({nm, "_busy"}, busy, 1'b0);
    chk({nm, "_cycles"}, cyc, e_cyc);
    chk({nm, "_pc"}, pc, e_pc);
    chk({nm, "_last_result"}, last_result, e_r);
    chk({nm, "_last_flags"}, {last_z, last_c, last_v}, {e_z, e_c, e_v});
    chk({nm, "_issues_left"}, exp_q.size(), 0);
    m_r = e_r; m_z = e_z; m_c = e_c; m_v = e_v;
    sb_en = 1'b0;
  endtask

  function automatic logic [7:0] rnd_word();
    logic [7:0] w;
    int k = int'($urandom_range(0, 9));
    if (k < 6) begin
      w = 8'($urandom);
      while (w[7:4] == 4'hC || w[7:4] == 4'hD || w[7:4] == 4'hE || w == 8'hF0)
        w = 8'($urandom);
    end else if (k == 6) w = {4'hD, 4'($urandom)};
    else if (k == 7) w = {4'hE, 4'($urandom)};
    else if (k == 8) w = {4'hC, 4'($urandom)};
    else w = 8'hF0;
    return w;
  endfunction

  initial begin
    int cyc;
    int t;
    bit ok, wrap;
    logic [3:0] prev, wa;
    logic [7:0] wd;
    bit wr;

    for (int i = 0; i < 256; i++) begin
      core_r[i] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      core_c[i] = 1'($urandom);
      core_v[i] = 1'($urandom);
    end
    m_r = '0; m_z = 0; m_c = 0; m_v = 0;

    // T1 reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t1_instr", instr, 8'h00);
    chk("t1_valid", instr_valid, 1'b0);
    chk("t1_pc", pc, 4'd0);
    chk("t1_busy", busy, 1'b0);
    chk("t1_done", done, 1'b0);
    chk("t1_last", last_result, 8'h00);
    rst = 1'b0;

    // T2 single MUL 5*3
    core_r[8'h30] = 8'h0F; core_c[8'h30] = 0; core_v[8'h30] = 0;
    for (int i = 0; i < 16; i++) ld[i] = 8'hF0;
    ld[0] = 8'h30;
    load_prog();
    run_prog("t2", 0, 0, 0, -1, cyc);
    chk("t2_six_clks", cyc, 6);
    chk("t2_pc1", pc, 4'd1);
    chk("t2_res0f", last_result, 8'h0F);
    chk("t2_z0", last_z, 1'b0);

    // T3 JZ taken, then not taken
    ld[0] = 8'h33; ld[1] = 8'hE3; ld[2] = 8'hF0; ld[3] = 8'h34; ld[4] = 8'hF0;
    load_prog();
    core_r[8'h33] = 8'h00;
    run_prog("t3_taken", 0, 0, 0, -1, cyc);
    chk("t3_taken_pc4", pc, 4'd4);
    core_r[8'h33] = 8'h05;
    run_prog("t3_fall", 0, 0, 0, -1, cyc);
    chk("t3_fall_pc2", pc, 4'd2);

    // T5 write and start while busy are ignored
    for (int i = 0; i < 16; i++) ld[i] = 8'hF0;
    for (int i = 0; i < 5; i++) ld[i] = 8'h01;
    load_prog();
    run_prog("t5_busy", 0, 0, 0, 7, cyc);
    run_prog("t5_again", 0, 0, 0, -1, cyc);

    // random programs, sometimes written in the start cycle
    for (int n = 0; n < 24; n++) begin
      ok = 0;
      for (int a = 0; a < 200 && !ok; a++) begin
        for (int i = 0; i < 16; i++) ld[i] = rnd_word();
        for (int i = 0; i < 16; i++) img[i] = ld[i];
        wr = 1'($urandom);
        wa = 4'($urandom);
        wd = rnd_word();
        if (wr) img[wa] = wd;
        model_run(ok);
      end
      if (!ok) begin
        for (int i = 0; i < 16; i++) ld[i] = 8'hF0;
        wr = 0;
      end
      load_prog();
      run_prog("rand", wr, wa, wd, -1, cyc);
    end

    // T4 wrap through ram[15]=JMP 0, then abort during an issue
    core_r[8'h30] = 8'h21; core_r[8'h01] = 8'h42;
    for (int i = 0; i < 16; i++) ld[i] = 8'h01;
    ld[0] = 8'h30; ld[15] = 8'hD0;
    load_prog();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wrap = 0; prev = pc;
    for (t = 0; t < 400 && !wrap; t++) begin
      @(negedge clk);
      if ($isunknown(pc)) chk("t4_pc_known", 0, 1);
      if (prev == 4'd15 && pc == 4'd0) wrap = 1;
      prev = pc;
    end
    chk("t4_wrap_seen", wrap, 1'b1);
    for (t = 0; t < 50; t++) begin
      if (instr_valid && instr == 8'h30) break;
      @(negedge clk);
    end
    chk("t4_issue30", instr_valid && instr == 8'h30, 1'b1);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("t4_abort_valid", instr_valid, 1'b0);
    chk("t4_abort_busy", busy, 1'b0);
    chk("t4_abort_last", last_result, 8'h42);

    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    m_r = '0; m_z = 0; m_c = 0; m_v = 0;

    // T6 reset in WAIT after a run left non-zero last_*
    core_r[8'h01] = 8'h77; core_c[8'h01] = 1; core_v[8'h01] = 1;
    for (int i = 0; i < 16; i++) ld[i] = 8'hF0;
    ld[0] = 8'h01;
    load_prog();
    run_prog("t6_pre", 0, 0, 0, -1, cyc);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (t = 0; t < 20 && !instr_valid; t++) @(negedge clk);
    chk("t6_issued", instr_valid, 1'b1);
    @(negedge clk);
    chk("t6_in_wait", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_busy", busy, 1'b0);
    chk("t6_valid", instr_valid, 1'b0);
    chk("t6_pc", pc, 4'd0);
    chk("t6_last", {last_result, last_z, last_c, last_v}, 11'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
